// File: rtl/input_debouncer.sv
// Two-flop synchronizer plus per-bit stability counters: an output bit only
// follows its pin after the new level has held for STABLE prescaler ticks.
module input_debouncer #(
  parameter int WIDTH    = 8,
  parameter int PRESCALE = 1,
  parameter int STABLE   = 4
) (
  input  logic             CLK,
  input  logic             ASYNCRESET,
  input  logic [WIDTH-1:0] I,
  output logic [WIDTH-1:0] O,
  output logic             CHANGED
);

  localparam int CW = $clog2(STABLE + 1);
  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CW-1:0] CNT_LAST  = CW'(STABLE - 1);
  localparam logic [PW-1:0] PCNT_LAST = PW'(PRESCALE - 1);

  logic [WIDTH-1:0]         s1_q, s2_q;
  logic [PW-1:0]            pcnt_q, pcnt_d;
  logic                     tick;
  logic [WIDTH-1:0][CW-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0]         o_q, o_d;
  logic                     chg_q, chg_d;

  // Stage 0: synchronizer and prescaler
  assign tick = (pcnt_q == PCNT_LAST);

  always_ff @(posedge CLK or posedge ASYNCRESET) begin
    if (ASYNCRESET) begin
      s1_q   <= '0;
      s2_q   <= '0;
      pcnt_q <= '0;
    end else begin
      s1_q   <= I;
      s2_q   <= s1_q;
      pcnt_q <= pcnt_d;
    end
  end

  // Stage 1: per-bit stability counters and registered outputs
  always_comb begin
    pcnt_d = tick ? '0 : pcnt_q + PW'(1);
    cnt_d  = cnt_q;
    o_d    = o_q;
    if (tick) begin
      for (int i = 0; i < WIDTH; i++) begin
        if (s2_q[i] == o_q[i]) begin
          cnt_d[i] = '0;
        end else if (cnt_q[i] == CNT_LAST) begin
          o_d[i]   = s2_q[i];
          cnt_d[i] = '0;
        end else begin
          cnt_d[i] = cnt_q[i] + CW'(1);
        end
      end
    end
    // One strobe per update edge, however many bits flip together.
    chg_d = |(o_d ^ o_q);
  end

  always_ff @(posedge CLK or posedge ASYNCRESET) begin
    if (ASYNCRESET) begin
      cnt_q <= '0;
      o_q   <= '0;
      chg_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      o_q   <= o_d;
      chg_q <= chg_d;
    end
  end

  assign O       = o_q;
  assign CHANGED = chg_q;

endmodule

// File: tb/tb_input_debouncer.sv
// Scoreboard bench for input_debouncer: expected (edge, O) pairs are queued as
// pins are driven and matched against each CHANGED strobe.
module tb_input_debouncer;

  localparam int W = 8;

  logic         CLK = 1'b0;
  logic         rst;
  logic [W-1:0] din, din2;
  logic [W-1:0] dout, dout2;
  logic         chg, chg2;

  always #5 CLK = ~CLK;

  input_debouncer #(.WIDTH(W), .PRESCALE(1), .STABLE(4)) dut (
    .CLK(CLK), .ASYNCRESET(rst), .I(din), .O(dout), .CHANGED(chg)
  );

  input_debouncer #(.WIDTH(W), .PRESCALE(4), .STABLE(2)) dut_ps (
    .CLK(CLK), .ASYNCRESET(rst), .I(din2), .O(dout2), .CHANGED(chg2)
  );

  typedef struct {
    int           cyc;
    logic [W-1:0] o;
  } exp_t;

  exp_t         sb_q[$];
  int           cyc = 0;
  int           n_tests = 0;
  int           n_fail = 0;
  int           chg2_cnt = 0;
  logic [W-1:0] prev_o;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Pins driven just after edge cyc settle before edge cyc+1; two sync edges
  // plus four ticks put the update on edge cyc+6.
  task automatic expect_update(input logic [W-1:0] o);
    exp_t e;
    e.cyc = cyc + 6;
    e.o   = o;
    sb_q.push_back(e);
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge CLK);
    #2;
  endtask

  always @(negedge CLK) begin
    exp_t e;
    if (!rst) begin
      if (chg === 1'b1) begin
        if (sb_q.size() == 0) begin
          check_eq("chg_unexpected", 32'(chg), 32'd0);
        end else begin
          e = sb_q.pop_front();
          check_eq("o_value", 32'(dout), 32'(e.o));
          check_eq("o_edge", 32'(cyc), 32'(e.cyc));
        end
      end else if (dout !== prev_o) begin
        check_eq("o_changed_silently", 32'(dout), 32'(prev_o));
      end
    end
    prev_o <= dout;
  end

  always @(negedge CLK) if (chg2 === 1'b1) chg2_cnt <= chg2_cnt + 1;

  initial begin
    int c0;
    int n;
    int base;

    rst  = 1'b1;
    din  = 8'hFF;
    din2 = '0;

    // Held in reset with all pins high
    for (int c = 0; c < 5; c++) begin
      @(negedge CLK);
      check_eq("rst_o", 32'(dout), 32'd0);
      check_eq("rst_chg", 32'(chg), 32'd0);
    end
    @(posedge CLK); #2;
    rst = 1'b0;
    expect_update(8'hFF);
    wait_cycles(10);
    check_eq("rst_release_o", 32'(dout), 32'hFF);
    check_eq("rst_release_drain", 32'(sb_q.size()), 32'd0);

    // Return to all-low, then a 3-cycle glitch on bit 3
    din = 8'h00;
    expect_update(8'h00);
    wait_cycles(10);
    din = 8'h08;
    wait_cycles(3);
    din = 8'h00;
    wait_cycles(10);
    check_eq("glitch_o", 32'(dout), 32'd0);
    check_eq("glitch_drain", 32'(sb_q.size()), 32'd0);

    // Bounce 1,0,1,0 on bit 0, then settle high
    din = 8'h01; wait_cycles(1);
    din = 8'h00; wait_cycles(1);
    din = 8'h01; wait_cycles(1);
    din = 8'h00; wait_cycles(1);
    din = 8'h01;
    expect_update(8'h01);
    wait_cycles(10);
    check_eq("bounce_o", 32'(dout), 32'h01);
    check_eq("bounce_drain", 32'(sb_q.size()), 32'd0);

    // Several bits flipping in the same cycle
    din = 8'h00;
    expect_update(8'h00);
    wait_cycles(10);
    din = 8'hA5;
    expect_update(8'hA5);
    wait_cycles(10);
    check_eq("multi_o", 32'(dout), 32'hA5);
    check_eq("multi_drain", 32'(sb_q.size()), 32'd0);

    // Asynchronous reset in the middle of a count
    din = 8'hFF;
    wait_cycles(3);
    #1 rst = 1'b1;
    #1;
    check_eq("arst_o_immediate", 32'(dout), 32'd0);
    check_eq("arst_chg", 32'(chg), 32'd0);
    wait_cycles(2);
    check_eq("arst_o_held", 32'(dout), 32'd0);
    rst = 1'b0;
    expect_update(8'hFF);
    wait_cycles(10);
    check_eq("arst_restart_o", 32'(dout), 32'hFF);
    check_eq("arst_drain", 32'(sb_q.size()), 32'd0);

    // PRESCALE=4, STABLE=2 instance: latency window, then a short low pulse
    base = chg2_cnt;
    din2[5] = 1'b1;
    c0 = cyc;
    n  = -1;
    for (int k = 0; k < 14 && n < 0; k++) begin
      @(negedge CLK);
      if (dout2[5] === 1'b1) begin
        n = cyc - c0;
        check_eq("ps_chg_on_rise", 32'(chg2), 32'd1);
      end
    end
    check_eq("ps_rise", 32'(dout2[5]), 32'd1);
    check_eq("ps_latency_min", 32'(n >= 7), 32'd1);
    check_eq("ps_latency_max", 32'(n <= 10), 32'd1);
    check_eq("ps_other_bits", 32'(dout2), 32'h20);
    @(posedge CLK); #2;
    din2[5] = 1'b0;
    wait_cycles(3);
    din2[5] = 1'b1;
    wait_cycles(14);
    check_eq("ps_pulse_o", 32'(dout2[5]), 32'd1);
    check_eq("ps_chg_count", 32'(chg2_cnt - base), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
